// File: rtl/mybusmatrix5x7_rrarb_s3.sv
// Round-robin, burst-aware output arbiter for slave port S3 of the 5x7 bus
// matrix. Shares S3 between input ports 2, 3 and 4. Arbitration is frozen
// inside defined-length bursts and locked sequences. Undefined-length INCR
// bursts are capped at INCR_MAX accepted beats.
//
// State | meaning
// ------+---------------------------------------------------------------
// owner | addr_in_port: last granted port (3'b000 only after reset)
// idle  | no_port=1: S3 not driven by any port, owner value retained
// hold  | burst_hold=1: beats remain in burst, or locked; owner frozen
// cnt   | remaining beats after the current one (0 = may re-arbitrate)

module mybusmatrix5x7_rrarb_s3 #(
    parameter int unsigned INCR_MAX = 8
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       req_port2,
    input  logic       req_port3,
    input  logic       req_port4,
    input  logic       HREADYM,
    input  logic       HSELM,
    input  logic [1:0] HTRANSM,
    input  logic [2:0] HBURSTM,
    input  logic       HMASTLOCKM,
    output logic [2:0] addr_in_port,
    output logic       no_port,
    output logic       burst_hold
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    localparam logic [2:0] PORT2 = 3'b010;
    localparam logic [2:0] PORT3 = 3'b011;
    localparam logic [2:0] PORT4 = 3'b100;

    localparam logic [4:0] INCR_LOAD = 5'(INCR_MAX - 1);

    logic [4:0] cnt;
    logic [4:0] cnt_nxt;
    logic       incr_mode;
    logic       incr_nxt;
    logic       hold;
    logic       any_req;
    logic [2:0] grant;

    // incr_mode is kept as burst-type status for observation; no arbitration
    // decision currently depends on it because the cap is folded into cnt.
    logic unused_incr_mode;
    assign unused_incr_mode = incr_mode;

    // Next beat count and burst mode from the transfer presented this cycle
    always_comb begin
        cnt_nxt  = cnt;
        incr_nxt = incr_mode;
        if (!HSELM || HTRANSM == TRANS_IDLE) begin
            cnt_nxt = 5'd0;
        end else if (HTRANSM == TRANS_NONSEQ) begin
            case (HBURSTM)
                3'b000: begin
                    cnt_nxt  = 5'd0;
                    incr_nxt = 1'b0;
                end
                3'b001: begin
                    cnt_nxt  = INCR_LOAD;
                    incr_nxt = 1'b1;
                end
                3'b010, 3'b011: begin
                    cnt_nxt  = 5'd3;
                    incr_nxt = 1'b0;
                end
                3'b100, 3'b101: begin
                    cnt_nxt  = 5'd7;
                    incr_nxt = 1'b0;
                end
                default: begin
                    cnt_nxt  = 5'd15;
                    incr_nxt = 1'b0;
                end
            endcase
        end else if (HTRANSM == TRANS_SEQ) begin
            cnt_nxt = (cnt != 5'd0) ? cnt - 5'd1 : 5'd0;
        end
    end

    // Freeze arbitration while locked or while beats of a burst remain
    always_comb begin
        hold = HMASTLOCKM
             | (HSELM && (HTRANSM != TRANS_IDLE) && (cnt_nxt != 5'd0));
    end

    // Round-robin pick: search starts at the port after the current owner
    always_comb begin
        any_req = req_port2 | req_port3 | req_port4;
        grant   = addr_in_port;
        case (addr_in_port)
            PORT2: begin
                if (req_port3)      grant = PORT3;
                else if (req_port4) grant = PORT4;
                else if (req_port2) grant = PORT2;
            end
            PORT3: begin
                if (req_port4)      grant = PORT4;
                else if (req_port2) grant = PORT2;
                else if (req_port3) grant = PORT3;
            end
            default: begin
                // Owner is port 4, or nothing granted since reset.
                if (req_port2)      grant = PORT2;
                else if (req_port3) grant = PORT3;
                else if (req_port4) grant = PORT4;
            end
        endcase
    end

    // Registered owner, select and counter; everything advances on HREADYM only
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_in_port <= 3'b000;
            no_port      <= 1'b1;
            burst_hold   <= 1'b0;
            cnt          <= 5'd0;
            incr_mode    <= 1'b0;
        end else if (HREADYM) begin
            cnt       <= cnt_nxt;
            incr_mode <= incr_nxt;
            if (hold) begin
                no_port    <= 1'b0;
                burst_hold <= 1'b1;
            end else begin
                burst_hold <= 1'b0;
                if (any_req) begin
                    addr_in_port <= grant;
                    no_port      <= 1'b0;
                end else begin
                    no_port <= ~HSELM;
                end
            end
        end
    end

endmodule

// File: tb/tb_mybusmatrix5x7_rrarb_s3.sv
// Directed bench for the S3 round-robin burst-aware arbiter (INCR_MAX=4).
module tb_mybusmatrix5x7_rrarb_s3;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic       req_port2, req_port3, req_port4;
    logic       HREADYM, HSELM, HMASTLOCKM;
    logic [1:0] HTRANSM;
    logic [2:0] HBURSTM;
    logic [2:0] addr_in_port;
    logic       no_port;
    logic       burst_hold;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] IDL = 2'b00, BSY = 2'b01, NSQ = 2'b10, SQ = 2'b11;
    localparam logic [2:0] SGL = 3'b000, INC = 3'b001, I4 = 3'b011,
                           W8 = 3'b100, W16 = 3'b110;

    mybusmatrix5x7_rrarb_s3 #(.INCR_MAX(4)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .req_port2    (req_port2),
        .req_port3    (req_port3),
        .req_port4    (req_port4),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port),
        .burst_hold   (burst_hold)
    );

    always #5 HCLK = ~HCLK;

    // req = {req_port4, req_port3, req_port2}
    typedef struct {
        logic [2:0] req;
        logic       rdy;
        logic       sel;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       lock;
        logic [2:0] e_port;
        logic       e_no;
        logic       e_hold;
    } vec_t;

    vec_t vecs[$];

    task automatic check_out(input string name, input logic [2:0] ep,
                             input logic en, input logic eh);
        checks++;
        if (addr_in_port !== ep || no_port !== en || burst_hold !== eh) begin
            errors++;
            $display("FAIL %s: got port=%b no_port=%b hold=%b, want port=%b no_port=%b hold=%b",
                     name, addr_in_port, no_port, burst_hold, ep, en, eh);
        end
    endtask

    task automatic drive(input vec_t v);
        {req_port4, req_port3, req_port2} = v.req;
        HREADYM    = v.rdy;
        HSELM      = v.sel;
        HTRANSM    = v.trans;
        HBURSTM    = v.burst;
        HMASTLOCKM = v.lock;
    endtask

    initial begin
        // Grant port 3 from reset
        vecs.push_back('{3'b010, 1, 0, IDL, SGL, 0, 3'b011, 0, 0});
        // Move owner to port 2
        vecs.push_back('{3'b001, 1, 0, IDL, SGL, 0, 3'b010, 0, 0});
        // Round robin with all requests, owner issues SINGLE
        vecs.push_back('{3'b111, 1, 1, NSQ, SGL, 0, 3'b011, 0, 0});
        vecs.push_back('{3'b111, 1, 1, NSQ, SGL, 0, 3'b100, 0, 0});
        vecs.push_back('{3'b111, 1, 1, NSQ, SGL, 0, 3'b010, 0, 0});
        vecs.push_back('{3'b111, 1, 1, NSQ, SGL, 0, 3'b011, 0, 0});
        // Owner to port 4, then INCR4 with two wait states, req2 held
        vecs.push_back('{3'b100, 1, 0, IDL, SGL, 0, 3'b100, 0, 0});
        vecs.push_back('{3'b001, 1, 1, NSQ, I4,  0, 3'b100, 0, 1});
        vecs.push_back('{3'b001, 1, 1, SQ,  I4,  0, 3'b100, 0, 1});
        vecs.push_back('{3'b001, 0, 1, SQ,  I4,  0, 3'b100, 0, 1});
        vecs.push_back('{3'b001, 0, 1, SQ,  I4,  0, 3'b100, 0, 1});
        vecs.push_back('{3'b001, 1, 1, SQ,  I4,  0, 3'b100, 0, 1});
        vecs.push_back('{3'b001, 1, 1, SQ,  I4,  0, 3'b010, 0, 0});
        // INCR capped at 4 beats, req3 held, BUSY in the middle
        vecs.push_back('{3'b010, 1, 1, NSQ, INC, 0, 3'b010, 0, 1});
        vecs.push_back('{3'b010, 1, 1, SQ,  INC, 0, 3'b010, 0, 1});
        vecs.push_back('{3'b010, 1, 1, BSY, INC, 0, 3'b010, 0, 1});
        vecs.push_back('{3'b010, 1, 1, SQ,  INC, 0, 3'b010, 0, 1});
        vecs.push_back('{3'b010, 1, 1, SQ,  INC, 0, 3'b011, 0, 0});
        vecs.push_back('{3'b010, 1, 1, SQ,  INC, 0, 3'b011, 0, 0});
        // Locked port 3 over SINGLE/IDLE, req2 held, then release on IDLE
        vecs.push_back('{3'b001, 1, 1, NSQ, SGL, 1, 3'b011, 0, 1});
        vecs.push_back('{3'b001, 1, 1, IDL, SGL, 1, 3'b011, 0, 1});
        vecs.push_back('{3'b001, 1, 1, NSQ, SGL, 1, 3'b011, 0, 1});
        vecs.push_back('{3'b001, 1, 1, IDL, SGL, 1, 3'b011, 0, 1});
        vecs.push_back('{3'b001, 1, 1, NSQ, SGL, 1, 3'b011, 0, 1});
        vecs.push_back('{3'b001, 1, 1, IDL, SGL, 0, 3'b010, 0, 0});
        // WRAP8 terminated early by IDLE with HSELM=0, no requests
        vecs.push_back('{3'b000, 1, 1, NSQ, W8,  0, 3'b010, 0, 1});
        vecs.push_back('{3'b000, 1, 1, SQ,  W8,  0, 3'b010, 0, 1});
        vecs.push_back('{3'b000, 1, 1, SQ,  W8,  0, 3'b010, 0, 1});
        vecs.push_back('{3'b000, 1, 0, IDL, W8,  0, 3'b010, 1, 0});
        // Counter was cleared: a stray SEQ does not re-freeze; selected, no req
        vecs.push_back('{3'b000, 1, 1, SQ,  W8,  0, 3'b010, 0, 0});
        // Wait state delays a grant
        vecs.push_back('{3'b100, 0, 0, IDL, SGL, 0, 3'b010, 0, 0});
        vecs.push_back('{3'b100, 1, 0, IDL, SGL, 0, 3'b100, 0, 0});
        // WRAP16 start, reset lands mid-burst below
        vecs.push_back('{3'b000, 1, 1, NSQ, W16, 0, 3'b100, 0, 1});

        drive('{3'b000, 1, 0, IDL, SGL, 0, 3'b000, 0, 0});
        HRESETn = 1'b0;
        #12;
        check_out("reset", 3'b000, 1'b1, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;
        check_out("idle_after_reset", 3'b000, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            @(posedge HCLK);
            #1;
            check_out($sformatf("vec%0d", i), vecs[i].e_port, vecs[i].e_no,
                      vecs[i].e_hold);
        end

        // Asynchronous reset in the middle of the WRAP16, between edges
        drive('{3'b000, 1, 1, SQ, W16, 0, 3'b000, 0, 0});
        #2;
        HRESETn = 1'b0;
        #1;
        check_out("async_reset_midburst", 3'b000, 1'b1, 1'b0);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Round-robin start point after reset is port 2
        drive('{3'b111, 1, 0, IDL, SGL, 0, 3'b000, 0, 0});
        @(posedge HCLK);
        #1;
        check_out("rr_start_after_reset", 3'b010, 1'b0, 1'b0);

        // No combinational path: input change before the edge is invisible
        drive('{3'b010, 1, 0, IDL, SGL, 0, 3'b000, 0, 0});
        #2;
        check_out("no_comb_path", 3'b010, 1'b0, 1'b0);
        @(posedge HCLK);
        #1;
        check_out("grant_after_edge", 3'b011, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, want finish before 100000");
        $fatal(1);
    end

endmodule
